// File: rtl/mem_pkg.sv
// Shared types and constants for the memory front-end arbiter.
package mem_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Grant encoding: the o_grant_d output uses the same polarity.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  // Winner of an arbitration round. A lone requester always wins; on a tie,
  // fixed priority favours D, otherwise the port that lost last time wins.
  function automatic logic pick_grant(input logic req_i,
                                      input logic req_d,
                                      input logic last_grant,
                                      input logic fixed_prio);
    logic winner;
    if (req_i && req_d) begin
      winner = fixed_prio ? GRANT_D : ~last_grant;
    end else begin
      winner = req_d ? GRANT_D : GRANT_I;
    end
    return winner;
  endfunction

endpackage

// File: rtl/wb_arbiter_2to1_if.sv
// Wishbone classic bundle. The controller modport starts cycles, the
// peripheral modport answers them.
interface wb_if;
  import mem_pkg::*;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [WB_ADDR_W-1:0] addr;
  logic [WB_SEL_W-1:0]  sel;
  logic [WB_DATA_W-1:0] data_wr;
  logic [WB_DATA_W-1:0] data_rd;
  logic                 ack;
  logic                 err;

  modport controller (
    output cyc, stb, we, addr, sel, data_wr,
    input  data_rd, ack, err
  );

  modport peripheral (
    input  cyc, stb, we, addr, sel, data_wr,
    output data_rd, ack, err
  );

endinterface

// File: rtl/wb_arbiter_2to1_timeout.sv
// Bus-hang watchdog: counts BUSY cycles of the current grant and flags the
// cycle in which the limit is reached. A limit of 0 disables the watchdog.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // The count holds the number of BUSY cycles already completed, so the
  // limit is hit while the TIMEOUT_CYCLES-th cycle is in progress.
  localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                   ENABLED  = (TIMEOUT_CYCLES != 0);

  logic [TIMEOUT_W-1:0] count_q;

  // Cleared on every new grant, advanced once per BUSY cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Expiry is only meaningful while the owner is being serviced.
  always_comb begin
    expire = ENABLED && en && (count_q == LAST_CNT);
  end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-to-one Wishbone classic arbiter: instruction fetch (I) and data
// membus (D) share one downstream controller port. One transaction per
// grant, at least one idle cycle between grants, watchdog on hung cycles.
module wb_arbiter_2to1
  import mem_pkg::*;
#(
  parameter int unsigned PRIORITY_DMEM  = 1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TIMEOUT_W      = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  wb_if.peripheral wb_i,
  wb_if.peripheral wb_d,
  wb_if.controller wb_out,
  output logic o_busy,
  output logic o_grant_d,
  output logic o_timeout
);

  localparam logic FIXED_PRIO = (PRIORITY_DMEM != 0);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       grant_q;
  logic       grant_d;
  logic       start;

  logic req_i;
  logic req_d;
  logic busy;

  logic own_cyc;
  logic own_stb;
  logic term;
  logic expire;
  logic tmo_fire;
  logic ack_route;
  logic err_route;

  assign req_i = wb_i.cyc & wb_i.stb;
  assign req_d = wb_d.cyc & wb_d.stb;
  assign busy  = (state_q == ARB_BUSY);

  // Handshake of whichever port currently owns the bus.
  assign own_cyc = (grant_q == GRANT_D) ? wb_d.cyc : wb_i.cyc;
  assign own_stb = (grant_q == GRANT_D) ? wb_d.stb : wb_i.stb;

  // A real ack/err always beats the watchdog in the same cycle.
  assign term     = own_cyc & (wb_out.ack | wb_out.err);
  assign tmo_fire = busy & own_cyc & expire & ~(wb_out.ack | wb_out.err);

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_timeout (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clr    (start),
    .en     (busy),
    .expire (expire)
  );

  // State and grant owner registers; the grant doubles as last-grant memory.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      grant_q <= GRANT_I;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next state: arbitrate in IDLE, leave BUSY on termination, abort or timeout.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    start   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (req_i || req_d) begin
          start   = 1'b1;
          state_d = ARB_BUSY;
          grant_d = pick_grant(req_i, req_d, grant_q, FIXED_PRIO);
        end
      end
      ARB_BUSY: begin
        if (!own_cyc || term || tmo_fire) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Downstream bus: owner's signals while BUSY, cycle killed on timeout.
  always_comb begin
    wb_out.cyc     = 1'b0;
    wb_out.stb     = 1'b0;
    wb_out.we      = (grant_q == GRANT_D) ? wb_d.we      : wb_i.we;
    wb_out.addr    = (grant_q == GRANT_D) ? wb_d.addr    : wb_i.addr;
    wb_out.sel     = (grant_q == GRANT_D) ? wb_d.sel     : wb_i.sel;
    wb_out.data_wr = (grant_q == GRANT_D) ? wb_d.data_wr : wb_i.data_wr;
    if (busy) begin
      wb_out.cyc = own_cyc & ~tmo_fire;
      wb_out.stb = own_cyc & own_stb & ~tmo_fire;
    end
  end

  // Termination reaches the owner only; nothing is returned while in reset
  // or after the owner has abandoned its cycle.
  assign ack_route = busy & own_cyc & wb_out.ack & ~i_rst;
  assign err_route = busy & own_cyc & (wb_out.err | tmo_fire) & ~i_rst;

  // Steer ack/err to the granted port; read data is broadcast.
  always_comb begin
    wb_i.ack     = 1'b0;
    wb_i.err     = 1'b0;
    wb_d.ack     = 1'b0;
    wb_d.err     = 1'b0;
    wb_i.data_rd = wb_out.data_rd;
    wb_d.data_rd = wb_out.data_rd;
    if (grant_q == GRANT_D) begin
      wb_d.ack = ack_route;
      wb_d.err = err_route;
    end else begin
      wb_i.ack = ack_route;
      wb_i.err = err_route;
    end
  end

  // Status outputs.
  always_comb begin
    o_busy    = busy;
    o_grant_d = grant_q;
    o_timeout = tmo_fire & ~i_rst;
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Bench for wb_arbiter_2to1: two instances (dut 0 fixed priority, dut 1
// round-robin, both with an 8-cycle watchdog) driven by directed vectors,
// checked every cycle against a transaction-level model plus literal checks.
module tb_wb_arbiter_2to1;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Requester side stimulus, indexed [dut][port], port 0 = I, 1 = D.
  logic [1:0]  rq_cyc [2];
  logic [1:0]  rq_stb [2];
  logic [1:0]  rq_we  [2];
  logic [31:0] rq_adr [2][2];
  logic [3:0]  rq_sel [2][2];
  logic [31:0] rq_dw  [2][2];
  // Downstream peripheral stimulus per dut.
  logic [1:0]  ds_ack;
  logic [1:0]  ds_err;
  logic [31:0] ds_drd [2];
  // Observed outputs.
  logic [1:0]  o_cyc, o_stb, o_we, o_busy, o_grant, o_tmo;
  logic [31:0] o_adr [2];
  logic [3:0]  o_sel [2];
  logic [31:0] o_dw  [2];
  logic [1:0]  p_ack [2];
  logic [1:0]  p_err [2];
  logic [31:0] p_drd [2][2];

  for (genvar g = 0; g < 2; g++) begin : h
    wb_if bi ();
    wb_if bd ();
    wb_if bo ();
    assign bi.cyc = rq_cyc[g][0];
    assign bi.stb = rq_stb[g][0];
    assign bi.we = rq_we[g][0];
    assign bi.addr = rq_adr[g][0];
    assign bi.sel = rq_sel[g][0];
    assign bi.data_wr = rq_dw[g][0];
    assign bd.cyc = rq_cyc[g][1];
    assign bd.stb = rq_stb[g][1];
    assign bd.we = rq_we[g][1];
    assign bd.addr = rq_adr[g][1];
    assign bd.sel = rq_sel[g][1];
    assign bd.data_wr = rq_dw[g][1];
    assign bo.ack = ds_ack[g];
    assign bo.err = ds_err[g];
    assign bo.data_rd = ds_drd[g];
    assign o_cyc[g] = bo.cyc;
    assign o_stb[g] = bo.stb;
    assign o_we[g] = bo.we;
    assign o_adr[g] = bo.addr;
    assign o_sel[g] = bo.sel;
    assign o_dw[g] = bo.data_wr;
    assign p_ack[g] = {bd.ack, bi.ack};
    assign p_err[g] = {bd.err, bi.err};
    assign p_drd[g][0] = bi.data_rd;
    assign p_drd[g][1] = bd.data_rd;

    wb_arbiter_2to1 #(
      .PRIORITY_DMEM  ((g == 0) ? 1 : 0),
      .TIMEOUT_CYCLES (TO),
      .TIMEOUT_W      (8)
    ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .wb_i      (bi),
      .wb_d      (bd),
      .wb_out    (bo),
      .o_busy    (o_busy[g]),
      .o_grant_d (o_grant[g]),
      .o_timeout (o_tmo[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h, required %0h", nm, k, $time, act, exp);
    end
  endtask

  // Transaction-level model: who owns each bus (-1 = nobody), how many BUSY
  // cycles the current grant has lasted, and who was granted last.
  int m_own  [2];
  int m_age  [2];
  int m_last [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_own[k] = -1;
        m_last[k] = 0;
        m_age[k] = 0;
      end else if (m_own[k] < 0) begin
        bit ri, rd;
        int win;
        ri = rq_cyc[k][0] && rq_stb[k][0];
        rd = rq_cyc[k][1] && rq_stb[k][1];
        if (ri || rd) begin
          if (ri && rd) win = (k == 0) ? 1 : 1 - m_last[k];
          else win = rd ? 1 : 0;
          m_own[k] = win;
          m_last[k] = win;
          m_age[k] = 1;
        end
      end else begin
        int o;
        bit oc, fin, tmo;
        o = m_own[k];
        oc = rq_cyc[k][o];
        fin = oc && (ds_ack[k] || ds_err[k]);
        tmo = oc && (m_age[k] == TO) && !fin;
        if (!oc || fin || tmo) m_own[k] = -1;
        else m_age[k] = m_age[k] + 1;
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int o;
        bit oc, fin, tmo, ecyc, estb;
        bit [1:0] eack, eerr;
        o = m_own[k];
        tmo = 0; ecyc = 0; estb = 0; eack = 0; eerr = 0;
        if (o >= 0) begin
          oc = rq_cyc[k][o];
          fin = oc && (ds_ack[k] || ds_err[k]);
          tmo = oc && (m_age[k] == TO) && !fin;
          ecyc = oc && !tmo;
          estb = oc && rq_stb[k][o] && !tmo;
          eack[o] = oc && ds_ack[k] && !rst;
          eerr[o] = oc && (ds_err[k] || tmo) && !rst;
        end
        chk("busy", k, 32'(o_busy[k]), 32'(o >= 0));
        chk("grant_d", k, 32'(o_grant[k]), 32'(m_last[k]));
        chk("port_ack", k, 32'(p_ack[k]), 32'(eack));
        chk("port_err", k, 32'(p_err[k]), 32'(eerr));
        chk("timeout", k, 32'(o_tmo[k]), 32'(tmo && !rst));
        chk("drd_i", k, p_drd[k][0], ds_drd[k]);
        chk("drd_d", k, p_drd[k][1], ds_drd[k]);
        if (!(rst && o >= 0)) begin
          chk("out_cyc", k, 32'(o_cyc[k]), 32'(ecyc));
          chk("out_stb", k, 32'(o_stb[k]), 32'(estb));
          if (ecyc) begin
            chk("out_addr", k, o_adr[k], rq_adr[k][o]);
            chk("out_we", k, 32'(o_we[k]), 32'(rq_we[k][o]));
            chk("out_sel", k, 32'(o_sel[k]), 32'(rq_sel[k][o]));
            chk("out_data", k, o_dw[k], rq_dw[k][o]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input int p, input logic we, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    rq_cyc[k][p] = 1'b1;
    rq_stb[k][p] = 1'b1;
    rq_we[k][p] = we;
    rq_adr[k][p] = a;
    rq_sel[k][p] = s;
    rq_dw[k][p] = d;
  endtask

  task automatic drop(input int k, input int p);
    rq_cyc[k][p] = 1'b0;
    rq_stb[k][p] = 1'b0;
  endtask

  logic [1:0] rr_seq [4];
  logic [1:0] rr_exp [4];

  initial begin
    rst = 1'b1;
    ds_ack = '0;
    ds_err = '0;
    for (int k = 0; k < 2; k++) begin
      rq_cyc[k] = '0;
      rq_stb[k] = '0;
      rq_we[k] = '0;
      ds_drd[k] = 32'h0;
      for (int p = 0; p < 2; p++) begin
        rq_adr[k][p] = '0;
        rq_sel[k][p] = '0;
        rq_dw[k][p] = '0;
      end
    end
    rr_exp[0] = 2'd1; rr_exp[1] = 2'd0; rr_exp[2] = 2'd1; rr_exp[3] = 2'd0;
    tick();
    #1;
    chk("rst_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("rst_cyc", 0, 32'(o_cyc[0]), 32'd0);
    chk("rst_grant", 1, 32'(o_grant[1]), 32'd0);
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: D alone writes, ack in its third BUSY cycle.
    tick();
    req(0, 1, 1'b1, 32'h100, 4'b0011, 32'h0000BEEF);
    ds_drd[0] = 32'h1234_5678;
    #1 chk("t1_idle", 0, 32'(o_busy[0]), 32'd0);
    tick();
    #1 chk("t1_addr", 0, o_adr[0], 32'h100);
    chk("t1_sel", 0, 32'(o_sel[0]), 32'h3);
    chk("t1_data", 0, o_dw[0], 32'h0000BEEF);
    chk("t1_grant", 0, 32'(o_grant[0]), 32'd1);
    tick();
    tick();
    ds_ack[0] = 1'b1;
    #1 chk("t1_ack", 0, 32'(p_ack[0]), 32'b10);
    tick();
    ds_ack[0] = 1'b0;
    drop(0, 1);
    #1 chk("t1_done", 0, 32'(o_busy[0]), 32'd0);

    // 2: simultaneous requests, fixed priority.
    tick();
    req(0, 0, 1'b0, 32'h2000, 4'hF, 32'h0);
    req(0, 1, 1'b1, 32'h300, 4'hC, 32'hCAFE_0001);
    tick();
    #1 chk("t2_first_d", 0, 32'(o_grant[0]), 32'd1);
    chk("t2_addr_d", 0, o_adr[0], 32'h300);
    ds_ack[0] = 1'b1;
    ds_drd[0] = 32'hA5A5_0F0F;
    tick();
    ds_ack[0] = 1'b0;
    drop(0, 1);
    #1 chk("t2_gap", 0, 32'(o_busy[0]), 32'd0);
    tick();
    #1 chk("t2_then_i", 0, 32'(o_grant[0]), 32'd0);
    chk("t2_addr_i", 0, o_adr[0], 32'h2000);
    ds_ack[0] = 1'b1;
    #1 chk("t2_ack_i", 0, 32'(p_ack[0]), 32'b01);
    tick();
    ds_ack[0] = 1'b0;
    drop(0, 0);

    // 3: round-robin, both ports keep requesting.
    tick();
    req(1, 0, 1'b0, 32'h10, 4'h1, 32'h11);
    req(1, 1, 1'b1, 32'h20, 4'h2, 32'h22);
    for (int n = 0; n < 4; n++) begin
      tick();
      rr_seq[n] = {1'b0, o_grant[1]};
      ds_ack[1] = 1'b1;
      tick();
      ds_ack[1] = 1'b0;
    end
    for (int n = 0; n < 4; n++) chk("t3_order", 1, 32'(rr_seq[n]), 32'(rr_exp[n]));
    drop(1, 0);
    drop(1, 1);

    // 4a: peripheral never answers I.
    tick();
    req(0, 0, 1'b0, 32'h4000, 4'hF, 32'h0);
    tick();
    repeat (6) tick();
    #1 chk("t4_not_yet", 0, 32'(o_tmo[0]), 32'd0);
    tick();
    #1 chk("t4_tmo", 0, 32'(o_tmo[0]), 32'd1);
    chk("t4_err", 0, 32'(p_err[0]), 32'b01);
    chk("t4_cyc", 0, 32'(o_cyc[0]), 32'd0);
    tick();
    drop(0, 0);
    #1 chk("t4_idle", 0, 32'(o_busy[0]), 32'd0);
    // 4b: ack lands exactly on the timeout cycle.
    tick();
    req(0, 1, 1'b1, 32'h5000, 4'h5, 32'h55);
    tick();
    repeat (7) tick();
    ds_ack[0] = 1'b1;
    #1 chk("t4b_ack", 0, 32'(p_ack[0]), 32'b10);
    chk("t4b_no_tmo", 0, 32'(o_tmo[0]), 32'd0);
    chk("t4b_cyc", 0, 32'(o_cyc[0]), 32'd1);
    tick();
    ds_ack[0] = 1'b0;
    drop(0, 1);

    // 5: reset in the third BUSY cycle.
    tick();
    req(0, 1, 1'b0, 32'h600, 4'hF, 32'h0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    ds_ack[0] = 1'b1;
    #1 chk("t5_no_ack", 0, 32'({p_ack[0], p_err[0]}), 32'd0);
    tick();
    rst = 1'b0;
    ds_ack[0] = 1'b0;
    #1 chk("t5_cyc_low", 0, 32'(o_cyc[0]), 32'd0);
    tick();
    #1 chk("t5_regrant", 0, 32'(o_busy[0]), 32'd1);
    ds_ack[0] = 1'b1;
    tick();
    ds_ack[0] = 1'b0;
    drop(0, 1);

    // 6: I abandons its cycle, late ack must vanish, then D is served.
    tick();
    req(0, 0, 1'b0, 32'h40, 4'hF, 32'h0);
    tick();
    tick();
    drop(0, 0);
    #1 chk("t6_abort_cyc", 0, 32'(o_cyc[0]), 32'd0);
    tick();
    #1 chk("t6_idle", 0, 32'(o_busy[0]), 32'd0);
    tick();
    ds_ack[0] = 1'b1;
    req(0, 1, 1'b1, 32'h700, 4'h8, 32'h77);
    #1 chk("t6_late_ack", 0, 32'(p_ack[0]), 32'b00);
    tick();
    ds_ack[0] = 1'b0;
    #1 chk("t6_d_grant", 0, 32'(o_grant[0]), 32'd1);
    chk("t6_d_busy", 0, 32'(o_busy[0]), 32'd1);
    ds_ack[0] = 1'b1;
    tick();
    ds_ack[0] = 1'b0;
    drop(0, 1);
    tick();
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
